// File: rtl/geig_stack_uart_tx.sv
// rtl/geig_stack_uart_tx.sv - Geiger data stack change detector and framed 8N1 UART transmitter
module geig_stack_uart_tx #(
    parameter int          CLKS_PER_BIT = 10,
    parameter logic [7:0]  SYNC_BYTE    = 8'h7E
) (
    input  logic        CLK_100KHZ,
    input  logic        RESET,
    input  logic [79:0] G_DATA_STACK,
    output logic        TX,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic        OVERRUN
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BYTE_LAST = 4'd11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [79:0]   shadow;
    logic [79:0]   frame_reg;
    logic [79:0]   pending;
    logic          pending_valid;
    logic [7:0]    shift;
    logic [7:0]    checksum;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [3:0]    byte_idx;
    logic          new_stack;
    logic [7:0]    frame_xor;
    logic [3:0]    next_idx;
    logic [7:0]    next_byte;
    logic          bit_end;

    // A stack is new when it differs from last cycle's copy and is not the handler's reset value
    always_comb begin
        new_stack = (G_DATA_STACK != shadow) && (G_DATA_STACK != 80'b0);
        bit_end   = (clk_cnt == BIT_LAST);
    end

    // XOR of the ten stack bytes held in the frame register
    always_comb begin
        frame_xor = 8'h00;
        for (int k = 0; k < 10; k++) begin
            frame_xor = frame_xor ^ frame_reg[8*k +: 8];
        end
    end

    // Byte that follows the current one: stack bytes MSB first, then the checksum
    always_comb begin
        next_idx  = byte_idx + 4'd1;
        next_byte = checksum;
        for (int k = 1; k <= 10; k++) begin
            if (next_idx == 4'(k)) begin
                next_byte = frame_reg[8*(11-k)-1 -: 8];
            end
        end
    end

    // Shadow copy of the input stack, refreshed every cycle
    always_ff @(posedge CLK_100KHZ) begin
        if (RESET) begin
            shadow <= 80'b0;
        end else begin
            shadow <= G_DATA_STACK;
        end
    end

    // Transmit FSM with registered serial outputs and the one-deep pending buffer
    always_ff @(posedge CLK_100KHZ) begin
        if (RESET) begin
            state         <= IDLE;
            frame_reg     <= 80'b0;
            pending       <= 80'b0;
            pending_valid <= 1'b0;
            shift         <= 8'h00;
            checksum      <= 8'h00;
            clk_cnt       <= '0;
            bit_idx       <= 3'd0;
            byte_idx      <= 4'd0;
            TX            <= 1'b1;
            BUSY          <= 1'b0;
            FRAME_DONE    <= 1'b0;
            OVERRUN       <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    TX       <= 1'b1;
                    BUSY     <= 1'b0;
                    clk_cnt  <= '0;
                    bit_idx  <= 3'd0;
                    byte_idx <= 4'd0;
                    if (pending_valid) begin
                        frame_reg     <= pending;
                        pending_valid <= 1'b0;
                        shift         <= SYNC_BYTE;
                        state         <= START;
                    end else if (new_stack) begin
                        frame_reg <= G_DATA_STACK;
                        shift     <= SYNC_BYTE;
                        state     <= START;
                    end
                end
                START: begin
                    TX   <= 1'b0;
                    BUSY <= 1'b1;
                    // frame_reg is stable from here to the end of the frame
                    if (byte_idx == 4'd0 && clk_cnt == '0) begin
                        checksum <= frame_xor;
                    end
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    TX <= shift[0];
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    TX <= 1'b1;
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx < BYTE_LAST) begin
                            byte_idx <= next_idx;
                            shift    <= next_byte;
                            state    <= START;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DONE: begin
                    TX         <= 1'b1;
                    BUSY       <= 1'b0;
                    FRAME_DONE <= 1'b1;
                    byte_idx   <= 4'd0;
                    state      <= IDLE;
                end
                default: begin
                    TX    <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // A stack arriving while a frame is in flight (or while pending is being drained) waits here
            if (new_stack && (state != IDLE || pending_valid)) begin
                pending       <= G_DATA_STACK;
                pending_valid <= 1'b1;
                if (state != IDLE && pending_valid) begin
                    OVERRUN <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_geig_stack_uart_tx.sv
// tb/tb_geig_stack_uart_tx.sv - directed self-checking bench for geig_stack_uart_tx
module tb_geig_stack_uart_tx;

    logic        CLK_100KHZ = 1'b0;
    logic        RESET;
    logic [79:0] G_DATA_STACK;
    logic        TX;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        OVERRUN;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_bytes [12];
    int         cap_wait;
    int         cap_frame_err;
    int         cap_edge_err;
    int         cap_tail_err;
    bit         cap_timeout;

    localparam logic [79:0] S1 = {32'hAAAAAAAA, 16'h0005, 24'h000258, 8'h47};
    localparam logic [79:0] SA = 80'h0123_4567_89AB_CDEF_1122;
    localparam logic [79:0] SB = 80'hFFEE_DDCC_BBAA_9988_7766;
    localparam logic [79:0] SC = 80'h5A5A_0F0F_F0F0_1234_8001;
    localparam logic [79:0] SD = 80'h0000_0000_0000_0000_00C3;

    geig_stack_uart_tx #(.CLKS_PER_BIT(10), .SYNC_BYTE(8'h7E)) dut (
        .CLK_100KHZ   (CLK_100KHZ),
        .RESET        (RESET),
        .G_DATA_STACK (G_DATA_STACK),
        .TX           (TX),
        .BUSY         (BUSY),
        .FRAME_DONE   (FRAME_DONE),
        .OVERRUN      (OVERRUN)
    );

    always #5 CLK_100KHZ = ~CLK_100KHZ;

    function automatic logic [95:0] exp_frame(input logic [79:0] s);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 10; k++) x = x ^ s[8*k +: 8];
        return {8'h7E, s, x};
    endfunction

    // Waits for a start bit, then samples 120 bit cells mid-bit and the FRAME_DONE/BUSY tail
    task automatic capture_frame();
        int bitn;
        int b;
        int p;
        cap_wait = 0; cap_frame_err = 0; cap_edge_err = 0; cap_tail_err = 0; cap_timeout = 0;
        for (int k = 0; k < 12; k++) cap_bytes[k] = 8'h00;
        while (1) begin
            @(negedge CLK_100KHZ);
            cap_wait++;
            if (TX === 1'b0) break;
            if (cap_wait >= 3000) begin
                cap_timeout = 1;
                return;
            end
        end
        for (int i = 0; i <= 1200; i++) begin
            if (i > 0) @(negedge CLK_100KHZ);
            if (i < 1200 && i % 10 == 5) begin
                bitn = i / 10;
                b = bitn / 10;
                p = bitn % 10;
                if (p == 0) begin
                    if (TX !== 1'b0) cap_frame_err++;
                end else if (p == 9) begin
                    if (TX !== 1'b1) cap_frame_err++;
                end else begin
                    cap_bytes[b][p-1] = TX;
                end
            end
            if (i < 1200 && i % 100 == 99 && TX !== 1'b1) cap_edge_err++;
            if (i < 1200 && i % 100 == 0 && TX !== 1'b0) cap_edge_err++;
            if (i == 1199 && (BUSY !== 1'b1 || FRAME_DONE !== 1'b0)) cap_tail_err++;
            if (i == 1200 && (BUSY !== 1'b0 || FRAME_DONE !== 1'b1)) cap_tail_err++;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK_100KHZ);
            if (FRAME_DONE === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        G_DATA_STACK = 80'b0;
        repeat (3) @(negedge CLK_100KHZ);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", TX); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", FRAME_DONE); end
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", OVERRUN); end
        RESET = 1'b0;
        repeat (5) @(negedge CLK_100KHZ);
        checks++; if (TX !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL idle_zero_stack: got tx=%b busy=%b expected tx=1 busy=0", TX, BUSY); end
    endtask

    task automatic test_single_frame();
        logic [7:0] hand [12];
        hand = '{8'h7E, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h05, 8'h00, 8'h02, 8'h58, 8'h47, 8'h18};
        G_DATA_STACK = S1;
        capture_frame();
        checks++; if (cap_timeout) begin errors++; $display("FAIL single_timeout: got no start bit expected one"); end
        checks++; if (cap_wait !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", cap_wait); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (cap_bytes[k] !== hand[k]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", k, cap_bytes[k], hand[k]); end
        end
        checks++; if (cap_frame_err !== 0) begin errors++; $display("FAIL single_start_stop: got %0d bad cells expected 0", cap_frame_err); end
        checks++; if (cap_edge_err !== 0) begin errors++; $display("FAIL single_byte_gap: got %0d bad edges expected 0", cap_edge_err); end
        checks++; if (cap_tail_err !== 0) begin errors++; $display("FAIL single_done_1200: got %0d bad samples expected 0", cap_tail_err); end
        @(negedge CLK_100KHZ);
        checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", FRAME_DONE); end
    endtask

    task automatic test_zero_repeat();
        int n;
        G_DATA_STACK = 80'b0;
        count_done(20, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL zero_stack_frames: got %0d expected 0", n); end
        G_DATA_STACK = S1;
        count_done(5000, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL repeat_frames: got %0d expected 1", n); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] ea;
        logic [95:0] eb;
        ea = exp_frame(SA);
        eb = exp_frame(SB);
        G_DATA_STACK = SA;
        fork
            capture_frame();
            begin repeat (300) @(negedge CLK_100KHZ); G_DATA_STACK = SB; end
        join
        checks++; if (cap_timeout) begin errors++; $display("FAIL pend_first_timeout: got no start bit expected one"); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (cap_bytes[k] !== ea[95-8*k -: 8]) begin errors++; $display("FAIL pend_first_byte%0d: got %h expected %h", k, cap_bytes[k], ea[95-8*k -: 8]); end
        end
        capture_frame();
        checks++; if (cap_timeout) begin errors++; $display("FAIL pend_second_timeout: got no start bit expected one"); end
        checks++; if (cap_wait !== 2) begin errors++; $display("FAIL pend_gap: got %0d expected 2", cap_wait); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (cap_bytes[k] !== eb[95-8*k -: 8]) begin errors++; $display("FAIL pend_second_byte%0d: got %h expected %h", k, cap_bytes[k], eb[95-8*k -: 8]); end
        end
        checks++; if (cap_frame_err !== 0 || cap_tail_err !== 0) begin errors++; $display("FAIL pend_second_timing: got %0d/%0d expected 0/0", cap_frame_err, cap_tail_err); end
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL pend_overrun: got %b expected 0", OVERRUN); end
    endtask

    task automatic test_overrun();
        logic [95:0] ea;
        logic [95:0] ec;
        int n;
        ea = exp_frame(SA);
        ec = exp_frame(SC);
        G_DATA_STACK = SA;
        fork
            capture_frame();
            begin
                repeat (300) @(negedge CLK_100KHZ); G_DATA_STACK = SB;
                repeat (300) @(negedge CLK_100KHZ); G_DATA_STACK = SC;
            end
        join
        checks++; if (cap_timeout) begin errors++; $display("FAIL ovr_first_timeout: got no start bit expected one"); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (cap_bytes[k] !== ea[95-8*k -: 8]) begin errors++; $display("FAIL ovr_first_byte%0d: got %h expected %h", k, cap_bytes[k], ea[95-8*k -: 8]); end
        end
        capture_frame();
        checks++; if (cap_timeout) begin errors++; $display("FAIL ovr_second_timeout: got no start bit expected one"); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (cap_bytes[k] !== ec[95-8*k -: 8]) begin errors++; $display("FAIL ovr_second_byte%0d: got %h expected %h", k, cap_bytes[k], ec[95-8*k -: 8]); end
        end
        checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", OVERRUN); end
        count_done(1500, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL ovr_extra_frames: got %0d expected 0", n); end
        checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", OVERRUN); end
    endtask

    task automatic test_reset_midframe();
        int n;
        G_DATA_STACK = SD;
        repeat (300) @(negedge CLK_100KHZ);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", BUSY); end
        RESET = 1'b1;
        G_DATA_STACK = 80'b0;
        @(negedge CLK_100KHZ);
        checks++; if (TX !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL mid_abort: got tx=%b busy=%b expected tx=1 busy=0", TX, BUSY); end
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL mid_overrun_clear: got %b expected 0", OVERRUN); end
        repeat (2) @(negedge CLK_100KHZ);
        RESET = 1'b0;
        count_done(1500, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", n); end
        checks++; if (TX !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL mid_idle_after: got tx=%b busy=%b expected tx=1 busy=0", TX, BUSY); end
    endtask

    initial begin
        RESET = 1'b1;
        G_DATA_STACK = 80'b0;
        test_reset();
        test_single_frame();
        test_zero_repeat();
        test_back_to_back();
        test_overrun();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
